id_ex_register: RTL and testbench

ID/EX pipeline register of the five-stage MIPS datapath. It captures the ID-stage control fields after the hazard bubble mux, together with the decoded operands and register specifiers, and presents them to the EX stage one cycle later. It supports hold (stall), flush (branch/jump squash) and bubble insertion. It also tracks a valid bit and a saturating count of bubbles entering EX.

---
 rtl/id_ex_register.sv | 154 +++++++++++++++
 tb/tb_id_ex_register.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the five-stage MIPS datapath.
// It captures the post-bubble-mux control fields, the decoded operands and the
// register specifiers. The EX stage sees them one cycle later.
// Priority at each edge is reset > flush > stall > load.
// validEx marks a real instruction in EX.
// bubbleCount counts bubbles entering EX and saturates at all-ones.
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      hazardBubble,
  // control fields, already passed through the hazard bubble mux
  input  logic                      hzdRegDest,
  input  logic [1:0]                hzdAluOp,
  input  logic                      hzdAluSrc,
  input  logic [2:0]                hzdMemControlIdEx,
  input  logic [1:0]                hzdWbControlIdEx,
  // ID data fields and register specifiers
  input  logic [DATA_WIDTH-1:0]     pcPlus4In,
  input  logic [DATA_WIDTH-1:0]     readData1In,
  input  logic [DATA_WIDTH-1:0]     readData2In,
  input  logic [DATA_WIDTH-1:0]     signExtImmIn,
  input  logic [REG_ADDR_WIDTH-1:0] rsIn,
  input  logic [REG_ADDR_WIDTH-1:0] rtIn,
  input  logic [REG_ADDR_WIDTH-1:0] rdIn,
  // registered EX-stage view
  output logic                      regDestEx,
  output logic [1:0]                aluOpEx,
  output logic                      aluSrcEx,
  output logic [2:0]                memControlEx,
  output logic [1:0]                wbControlEx,
  output logic [DATA_WIDTH-1:0]     pcPlus4Ex,
  output logic [DATA_WIDTH-1:0]     readData1Ex,
  output logic [DATA_WIDTH-1:0]     readData2Ex,
  output logic [DATA_WIDTH-1:0]     signExtImmEx,
  output logic [REG_ADDR_WIDTH-1:0] rsEx,
  output logic [REG_ADDR_WIDTH-1:0] rtEx,
  output logic [REG_ADDR_WIDTH-1:0] rdEx,
  output logic                      validEx,
  output logic                      memReadEx,
  output logic [COUNT_WIDTH-1:0]    bubbleCount
);

  // Control group. A bubble zeroes all of it at once.
  typedef struct packed {
    logic       reg_dest;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [2:0] mem_ctrl;   // {branch, memRead, memWrite}
    logic [1:0] wb_ctrl;    // {regWrite, memToReg}
  } ctrl_t;

  // Opaque data group. It passes through without arithmetic.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     read_data1;
    logic [DATA_WIDTH-1:0]     read_data2;
    logic [DATA_WIDTH-1:0]     sign_ext_imm;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } data_t;

  ctrl_t                  ctrl_in, ctrl_q, ctrl_d;
  data_t                  data_in, data_q, data_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   count_en;
  logic                   count_sat;

  // Pack the incoming fields. The controls are stored exactly as presented.
  // hazardBubble only affects the valid bit and the counter.
  always_comb begin
    ctrl_in.reg_dest      = hzdRegDest;
    ctrl_in.alu_op        = hzdAluOp;
    ctrl_in.alu_src       = hzdAluSrc;
    ctrl_in.mem_ctrl      = hzdMemControlIdEx;
    ctrl_in.wb_ctrl       = hzdWbControlIdEx;
    data_in.pc_plus4      = pcPlus4In;
    data_in.read_data1    = readData1In;
    data_in.read_data2    = readData2In;
    data_in.sign_ext_imm  = signExtImmIn;
    data_in.rs            = rsIn;
    data_in.rt            = rtIn;
    data_in.rd            = rdIn;
  end

  // Next-state selection. Flush overrides stall.
  // A flush counts as exactly one bubble, even when hazardBubble is also set.
  always_comb begin
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    valid_d  = valid_q;
    count_en = 1'b0;
    if (flush) begin
      ctrl_d   = '0;
      data_d   = '0;
      valid_d  = 1'b0;
      count_en = 1'b1;
    end else if (!stall) begin
      ctrl_d   = ctrl_in;
      data_d   = data_in;
      valid_d  = ~hazardBubble;
      count_en = hazardBubble;
    end
  end

  // Saturating bubble counter. It never wraps, and only reset clears it.
  assign count_sat = &count_q;

  always_comb begin
    count_d = count_q;
    if (count_en && !count_sat) count_d = count_q + COUNT_WIDTH'(1);
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign regDestEx    = ctrl_q.reg_dest;
  assign aluOpEx      = ctrl_q.alu_op;
  assign aluSrcEx     = ctrl_q.alu_src;
  assign memControlEx = ctrl_q.mem_ctrl;
  assign wbControlEx  = ctrl_q.wb_ctrl;
  assign pcPlus4Ex    = data_q.pc_plus4;
  assign readData1Ex  = data_q.read_data1;
  assign readData2Ex  = data_q.read_data2;
  assign signExtImmEx = data_q.sign_ext_imm;
  assign rsEx         = data_q.rs;
  assign rtEx         = data_q.rt;
  assign rdEx         = data_q.rd;
  assign validEx      = valid_q;
  assign bubbleCount  = count_q;

  // Load-use detection taps the stored memRead bit directly, with no extra stage.
  assign memReadEx    = ctrl_q.mem_ctrl[1];

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register.
// The stimulus issues directed vectors and pushes the expected EX-stage
// contents after each edge. A monitor pops one entry per cycle and compares
// every output against it.
module tb_id_ex_register;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct {
    logic          reg_dest;
    logic [1:0]    alu_op;
    logic          alu_src;
    logic [2:0]    mem;
    logic [1:0]    wb;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [AW-1:0] rs, rt, rd;
  } in_t;

  typedef struct {
    in_t           f;
    logic          valid;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset, stall, flush, hazardBubble;
  logic hzdRegDest, hzdAluSrc;
  logic [1:0] hzdAluOp, hzdWbControlIdEx;
  logic [2:0] hzdMemControlIdEx;
  logic [DW-1:0] pcPlus4In, readData1In, readData2In, signExtImmIn;
  logic [AW-1:0] rsIn, rtIn, rdIn;
  logic regDestEx, aluSrcEx, validEx, memReadEx;
  logic [1:0] aluOpEx, wbControlEx;
  logic [2:0] memControlEx;
  logic [DW-1:0] pcPlus4Ex, readData1Ex, readData2Ex, signExtImmEx;
  logic [AW-1:0] rsEx, rtEx, rdEx;
  logic [CW-1:0] bubbleCount;

  id_ex_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .hazardBubble(hazardBubble), .hzdRegDest(hzdRegDest), .hzdAluOp(hzdAluOp),
    .hzdAluSrc(hzdAluSrc), .hzdMemControlIdEx(hzdMemControlIdEx),
    .hzdWbControlIdEx(hzdWbControlIdEx), .pcPlus4In(pcPlus4In),
    .readData1In(readData1In), .readData2In(readData2In), .signExtImmIn(signExtImmIn),
    .rsIn(rsIn), .rtIn(rtIn), .rdIn(rdIn), .regDestEx(regDestEx), .aluOpEx(aluOpEx),
    .aluSrcEx(aluSrcEx), .memControlEx(memControlEx), .wbControlEx(wbControlEx),
    .pcPlus4Ex(pcPlus4Ex), .readData1Ex(readData1Ex), .readData2Ex(readData2Ex),
    .signExtImmEx(signExtImmEx), .rsEx(rsEx), .rtEx(rtEx), .rdEx(rdEx),
    .validEx(validEx), .memReadEx(memReadEx), .bubbleCount(bubbleCount)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t model;
  in_t  zero_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one registered EX view per cycle, compared on the falling edge.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("regDestEx",    32'(regDestEx),    32'(e.f.reg_dest));
      chk("aluOpEx",      32'(aluOpEx),      32'(e.f.alu_op));
      chk("aluSrcEx",     32'(aluSrcEx),     32'(e.f.alu_src));
      chk("memControlEx", 32'(memControlEx), 32'(e.f.mem));
      chk("wbControlEx",  32'(wbControlEx),  32'(e.f.wb));
      chk("pcPlus4Ex",    pcPlus4Ex,         e.f.pc);
      chk("readData1Ex",  readData1Ex,       e.f.rd1);
      chk("readData2Ex",  readData2Ex,       e.f.rd2);
      chk("signExtImmEx", signExtImmEx,      e.f.imm);
      chk("rsEx",         32'(rsEx),         32'(e.f.rs));
      chk("rtEx",         32'(rtEx),         32'(e.f.rt));
      chk("rdEx",         32'(rdEx),         32'(e.f.rd));
      chk("validEx",      32'(validEx),      32'(e.valid));
      chk("memReadEx",    32'(memReadEx),    32'(e.f.mem[1]));
      chk("bubbleCount",  32'(bubbleCount),  32'(e.cnt));
    end
  end

  function automatic in_t mk(input logic rdst, input logic [1:0] aop, input logic asrc,
                             input logic [2:0] mem, input logic [1:0] wb,
                             input logic [31:0] pc, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] imm,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    in_t v;
    v.reg_dest = rdst; v.alu_op = aop; v.alu_src = asrc; v.mem = mem; v.wb = wb;
    v.pc = pc; v.rd1 = r1; v.rd2 = r2; v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd;
    return v;
  endfunction

  // Drive one edge, then push the expected post-edge contents.
  task automatic step(input in_t v, input logic hb, input logic st, input logic fl, input logic rst);
    @(negedge clock);
    hzdRegDest = v.reg_dest; hzdAluOp = v.alu_op; hzdAluSrc = v.alu_src;
    hzdMemControlIdEx = v.mem; hzdWbControlIdEx = v.wb;
    pcPlus4In = v.pc; readData1In = v.rd1; readData2In = v.rd2; signExtImmIn = v.imm;
    rsIn = v.rs; rtIn = v.rt; rdIn = v.rd;
    hazardBubble = hb; stall = st; flush = fl; reset = rst;
    if (rst) begin
      model.f = zero_in; model.valid = 1'b0; model.cnt = '0;
    end else if (fl) begin
      model.f = zero_in; model.valid = 1'b0;
      if (model.cnt != {CW{1'b1}}) model.cnt = model.cnt + 1'b1;
    end else if (!st) begin
      model.f = v; model.valid = ~hb;
      if (hb && model.cnt != {CW{1'b1}}) model.cnt = model.cnt + 1'b1;
    end
    @(posedge clock);
    #1;
    sb_q.push_back(model);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t ones, a, b, c;
    zero_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model.f = zero_in; model.valid = 1'b0; model.cnt = '0;
    ones = mk(1, 2'b11, 1, 3'b111, 2'b11, '1, '1, '1, '1, '1, '1, '1);

    // Reset held for two edges with every input driven high.
    step(ones, 1, 1, 1, 1);
    step(ones, 1, 1, 1, 1);

    // Normal R-type load.
    a = mk(1, 2'b10, 0, 3'b000, 2'b10, 32'h0000_0004, 32'h0000_1234, 32'h0000_0055,
           32'h0000_0020, 5'd8, 5'd9, 5'd10);
    step(a, 0, 0, 0, 0);

    // Load-use: an lw reaches EX, then a bubble follows it.
    b = mk(0, 2'b00, 1, 3'b010, 2'b11, 32'h0000_0008, 32'h0000_1000, 32'h0,
           32'h0000_0010, 5'd1, 5'd2, 5'd0);
    step(b, 0, 0, 0, 0);
    c = mk(0, 0, 0, 0, 0, 32'h0000_000C, 32'h0000_0777, 32'h0000_0888, 32'h4, 5'd2, 5'd3, 5'd4);
    step(c, 1, 0, 0, 0);

    // Stall hold. The inputs change underneath, including a stalled hazardBubble.
    a = mk(1, 2'b10, 0, 3'b000, 2'b10, 32'h0000_0010, 32'h0000_0001, 32'hDEAD_BEEF,
           32'h0, 5'd3, 5'd4, 5'd5);
    step(a, 0, 0, 0, 0);
    step(mk(0, 2'b01, 1, 3'b100, 2'b00, 32'h14, 32'h2, 32'h1111_1111, 32'h1, 5'd6, 5'd7, 5'd8), 0, 1, 0, 0);
    step(zero_in, 1, 1, 0, 0);
    step(mk(1, 2'b11, 1, 3'b001, 2'b01, 32'h1C, 32'h3, 32'h2222_2222, 32'h2, 5'd9, 5'd10, 5'd11), 0, 1, 0, 0);
    // Stall released: the inputs present now are loaded.
    b = mk(0, 2'b00, 1, 3'b001, 2'b00, 32'h0000_0020, 32'h0000_00AA, 32'h0000_00BB,
           32'hFFFF_FFFC, 5'd12, 5'd13, 5'd14);
    step(b, 0, 0, 0, 0);

    // Flush beats stall while a valid instruction sits in EX.
    step(a, 0, 1, 1, 0);
    // Flush plus hazardBubble counts once.
    step(zero_in, 1, 0, 1, 0);
    // Protocol violation: the controls are stored unchanged and validEx is 0.
    step(mk(1, 2'b10, 1, 3'b110, 2'b11, 32'h30, 32'h5, 32'h6, 32'h7, 5'd15, 5'd16, 5'd17), 1, 0, 0, 0);

    // Saturation over 20 consecutive flushes, then a hold under stall.
    for (int i = 0; i < 20; i++) step(a, 0, 0, 1, 0);
    step(zero_in, 1, 1, 0, 0);
    step(zero_in, 1, 0, 0, 0);

    // Reset wins over a concurrent stall and flush, then a normal load follows.
    step(a, 1, 1, 1, 1);
    step(a, 0, 0, 0, 0);
    step(zero_in, 1, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
